write_buffer: RTL and testbench



---
 rtl/write_buffer_pkg.sv | 22 ++
 rtl/write_buffer_flex_counter.sv | 35 +++
 rtl/write_buffer.sv | 174 +++++++++++++++++
 tb/tb_write_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : write_buffer_pkg
//  Description : Shared types and constants for the pixel write buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package write_buffer_pkg;

    localparam int         BATCH      = 8;      // pixels per write batch
    localparam int         PIXEL_BITS = 24;     // RGB888
    localparam int         WORD_BYTES = 4;      // one pixel per 32-bit word
    localparam logic [7:0] PAD        = 8'h00;  // upper byte of each written word

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/write_buffer_flex_counter.sv
`default_nettype none
// ============================================================================
//  Module      : write_buffer_flex_counter
//  Description : Up-counter with programmable last value. Counts 0..rollover_val
//                and wraps to 0 on the enable that leaves rollover_val.
//                at_last flags that the current value is the last one.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_buffer_flex_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             at_last
);

    assign at_last = (count_out == rollover_val);

    // Count register: clear has priority over counting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= at_last ? '0 : count_out + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : write_buffer
//  Description : Collects filtered pixels in batches and writes each batch to
//                SDRAM as single-word Avalon-MM writes at consecutive word
//                addresses. Pulses done_write8 after each completed batch.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_buffer #(
    parameter int BATCH      = write_buffer_pkg::BATCH,
    parameter int PIXEL_BITS = write_buffer_pkg::PIXEL_BITS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [31:0]           base_address,
    input  logic [PIXEL_BITS-1:0] pixel_in,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    input  logic                  flush,
    output logic [31:0]           master_address,
    output logic                  master_write,
    output logic [31:0]           master_writedata,
    input  logic                  master_waitrequest,
    output logic                  done_write8,
    output logic                  write_busy
);
    import write_buffer_pkg::*;

    // Index width into the pixel buffer; counters hold indices only, and the
    // batch length is carried as the index of the last word to write.
    localparam int IW = (BATCH > 1) ? $clog2(BATCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BATCH - 1);

    state_t              state;
    state_t              next_state;

    logic [PIXEL_BITS-1:0] pix_buf [BATCH];
    logic [PIXEL_BITS-1:0] rd_pixel;
    logic [31:0]           word;

    logic [IW-1:0] fill_cnt;
    logic [IW-1:0] wr_cnt;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] len_last;
    logic          fill_last;
    logic          wr_last;
    logic          load_len;
    logic [31:0]   addr_reg;

    logic accept;
    logic wr_accept;
    logic start_take;
    logic cnt_clear;

    // start is honoured everywhere except WRITE so a transfer is never abandoned.
    assign start_take = start && (state != WRITE);
    assign accept     = (state == FILL) && pixel_valid;
    assign wr_accept  = (state == WRITE) && !master_waitrequest;
    assign cnt_clear  = (state == DONE) || start_take;

    write_buffer_flex_counter #(
        .WIDTH        (IW)
    ) u_fill_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (accept && !start),
        .rollover_val (LAST_IDX),
        .count_out    (fill_cnt),
        .at_last      (fill_last)
    );

    write_buffer_flex_counter #(
        .WIDTH        (IW)
    ) u_wr_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (wr_accept),
        .rollover_val (last_idx),
        .count_out    (wr_cnt),
        .at_last      (wr_last)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and batch-length selection on entry to WRITE.
    always_comb begin
        next_state = state;
        load_len   = 1'b0;
        len_last   = fill_cnt;
        case (state)
            IDLE: begin
                if (start) next_state = FILL;
            end
            FILL: begin
                if (start) begin
                    next_state = FILL;
                end else if (accept && (fill_last || flush)) begin
                    // The pixel accepted this cycle is the last one to write.
                    next_state = WRITE;
                    load_len   = 1'b1;
                    len_last   = fill_cnt;
                end else if (flush && (fill_cnt != '0)) begin
                    next_state = WRITE;
                    load_len   = 1'b1;
                    len_last   = fill_cnt - IW'(1);
                end
            end
            WRITE: begin
                if (wr_accept && wr_last) next_state = DONE;
            end
            DONE: begin
                next_state = FILL;
            end
            default: next_state = IDLE;
        endcase
    end

    // Index of the final word of the batch being written.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_idx <= '0;
        end else if (load_len) begin
            last_idx <= len_last;
        end
    end

    // Write address: reloaded on start, advances one word per accepted write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_reg <= '0;
        end else if (start_take) begin
            addr_reg <= base_address & 32'hFFFF_FFFC;
        end else if (wr_accept) begin
            addr_reg <= addr_reg + 32'(WORD_BYTES);
        end
    end

    // Pixel storage, written in place at the fill index; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_buf[fill_cnt] <= pixel_in;
        end
    end

    assign rd_pixel = pix_buf[wr_cnt];

    generate
        if (PIXEL_BITS == 24) begin : g_pad_rgb
            assign word = {PAD, rd_pixel};
        end else begin : g_pad_zext
            assign word = 32'(rd_pixel);
        end
    endgenerate

    // Outputs depend only on state and registers, never on live inputs.
    assign pixel_ready      = (state == FILL);
    assign master_write     = (state == WRITE);
    assign done_write8      = (state == DONE);
    assign write_busy       = (state == WRITE) || (state == DONE);
    assign master_address   = addr_reg;
    assign master_writedata = (state == WRITE) ? word : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_buffer
//  Description : Randomised scoreboard bench for write_buffer. The model keeps
//                the pending pixels and the running word address; each flushed
//                or full batch becomes a list of expected (address, data) words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_write_buffer;

    localparam int BATCH = 8;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_address = '0;
    logic [23:0] pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic        flush = 1'b0;
    logic [31:0] master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        master_waitrequest = 1'b0;
    logic        done_write8;
    logic        write_busy;

    write_buffer dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start              (start),
        .base_address       (base_address),
        .pixel_in           (pixel_in),
        .pixel_valid        (pixel_valid),
        .pixel_ready        (pixel_ready),
        .flush              (flush),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .done_write8        (done_write8),
        .write_busy         (write_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] pend_q[$];
    exp_t        e;
    logic [31:0] model_addr = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int batches = 0;
    int done_count = 0;
    int done_cyc = 0;
    int first_acc_cyc = 0;
    int wr_seen = 0;
    int stall_mode = 0;
    int dir_left = 0;
    bit pend_done = 0;
    bit prev_stall = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Avalon slave stall generator: none, random, or a directed 3-cycle stall
    // on the second write of a batch.
    always @(posedge clk) begin
        #1;
        if (stall_mode == 1) begin
            master_waitrequest = ($urandom_range(0, 2) == 0);
        end else if (stall_mode == 2 && master_write && wr_seen == 1 && dir_left > 0) begin
            master_waitrequest = 1'b1;
            dir_left--;
        end else begin
            master_waitrequest = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every accepted write and polices the
    // done pulse and stall stability.
    always @(negedge clk) begin
        if (n_rst) begin
            if (done_write8) begin
                done_count++;
                done_cyc = cyc;
            end
            if (pend_done) begin
                check("done_pulse", done_write8, 1);
                pend_done = 0;
            end else begin
                check("done_idle", done_write8, 0);
            end
            if (prev_stall) begin
                check("hold_write", master_write, 1);
                check("hold_addr", master_address, prev_addr);
                check("hold_data", master_writedata, prev_data);
            end
            if (master_write) begin
                check("busy_in_write", write_busy, 1);
                check("ready_in_write", pixel_ready, 0);
                if (!master_waitrequest) begin
                    wr_seen++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: addr %h data %h, none expected", master_address, master_writedata);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", master_address, e.addr);
                        check("wr_data", master_writedata, e.data);
                        if (e.last) pend_done = 1;
                    end
                end
            end
            prev_stall = master_write && master_waitrequest;
            prev_addr  = master_address;
            prev_data  = master_writedata;
        end else begin
            prev_stall = 0;
            pend_done  = 0;
        end
    end

    task automatic do_start(input logic [31:0] b);
        @(posedge clk); #1;
        start        = 1'b1;
        base_address = b;
        model_addr   = b & 32'hFFFF_FFFC;
        pend_q.delete();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Turn the pending pixels into expected writes at consecutive words.
    task automatic commit();
        exp_t x;
        while (pend_q.size() > 0) begin
            x.addr = model_addr;
            x.data = {8'h00, pend_q.pop_front()};
            x.last = (pend_q.size() == 0);
            exp_q.push_back(x);
            model_addr = model_addr + 32'd4;
        end
        batches++;
    endtask

    task automatic send_batch(input int n, input bit do_flush, input bit flush_last,
                              input bit gaps, input bit seq);
        int k = 0;
        int guard = 0;
        bit flushed = 0;
        while (k < n && guard < 200) begin
            @(posedge clk); #1;
            guard++;
            pixel_valid = !(gaps && $urandom_range(0, 3) == 0);
            pixel_in    = seq ? 24'(k + 1) : 24'($urandom);
            flush       = do_flush && flush_last && pixel_valid && (k == n - 1);
            @(negedge clk);
            if (pixel_valid) begin
                check("ready_in_fill", pixel_ready, 1);
                if (k == 0) first_acc_cyc = cyc;
                pend_q.push_back(pixel_in);
                k++;
                if (flush) flushed = 1;
            end
        end
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        flush       = do_flush && !flushed && (n < BATCH);
        if (flush) begin
            @(posedge clk); #1;
            flush = 1'b0;
        end
        if (n == BATCH || do_flush) commit();
    endtask

    task automatic wait_done();
        int g = 0;
        while (done_count < batches && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (done_count < batches) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: done pulses %0d expected %0d", done_count, batches);
            done_count = batches;
            exp_q.delete();
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_write();
        int g = 0;
        @(negedge clk);
        while (!master_write && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("write_seen", master_write, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write"}, master_write, 0);
        check({tag, "_addr"}, master_address, 0);
        check({tag, "_data"}, master_writedata, 0);
        check({tag, "_ready"}, pixel_ready, 0);
        check({tag, "_done"}, done_write8, 0);
        check({tag, "_busy"}, write_busy, 0);
    endtask

    initial begin
        // Reset values and idle behaviour before any start.
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", pixel_ready, 0);
            check("idle_write", master_write, 0);
        end

        // Full batch, no stalls, sequential data, 17-cycle batch.
        do_start(32'h0000_1000);
        send_batch(BATCH, 0, 0, 0, 1);
        wait_done();
        check("latency_17", done_cyc - first_acc_cyc, 16);

        // Directed 3-cycle stall on the second write.
        do_start(32'h0000_1000);
        wr_seen    = 0;
        dir_left   = 3;
        stall_mode = 2;
        send_batch(BATCH, 0, 0, 0, 1);
        wait_done();
        check("latency_stall", done_cyc - first_acc_cyc, 19);
        stall_mode = 0;

        // Partial batch by flush, then the next batch continues at base+12.
        do_start(32'h0000_2000);
        send_batch(3, 1, 0, 0, 1);
        wait_done();
        send_batch(BATCH, 0, 0, 0, 0);
        wait_done();

        // Address wrap across two batches; low address bits ignored.
        do_start(32'hFFFF_FFF3);
        send_batch(BATCH, 0, 0, 0, 0);
        wait_done();
        send_batch(BATCH, 0, 0, 0, 0);
        wait_done();

        // start during WRITE is ignored; the next batch follows the old one.
        do_start(32'h0000_3000);
        send_batch(BATCH, 0, 0, 0, 0);
        wait_write();
        @(posedge clk); #1;
        start        = 1'b1;
        base_address = 32'h0000_7000;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        send_batch(BATCH, 0, 0, 0, 0);
        wait_done();

        // start during FILL discards the partial batch.
        send_batch(5, 0, 0, 0, 0);
        do_start(32'h0000_9000);
        send_batch(BATCH, 0, 0, 0, 0);
        wait_done();

        // Randomised batches, flushes, restarts and stalls.
        stall_mode = 1;
        for (int i = 0; i < 30; i++) begin
            int n;
            if ($urandom_range(0, 4) == 0) do_start($urandom);
            n = $urandom_range(1, BATCH);
            send_batch(n, (n < BATCH), $urandom_range(0, 1) == 1, 1, 0);
            wait_done();
        end
        stall_mode = 0;

        // Reset asserted mid-WRITE.
        do_start(32'h0000_4000);
        send_batch(BATCH, 0, 0, 0, 0);
        wait_write();
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        pend_q.delete();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_ready", pixel_ready, 0);
            check("post_reset_write", master_write, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
